// File: rtl/stream_pair_monitor.sv
// Counts the four joint bit patterns of a stochastic bitstream pair over a window
// of 2^WIN_LOG2 valid samples and publishes the histogram at window end.
//
// state | meaning
// IDLE  | waiting for start; results of the last window held on cnt*
// RUN   | accumulating valid samples until the window fills or clear aborts
module stream_pair_monitor #(
    parameter int WIN_LOG2 = 8,
    parameter int CW       = WIN_LOG2 + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [1:0]    in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt11,
    output logic [CW-1:0] cnt10,
    output logic [CW-1:0] cnt01,
    output logic [CW-1:0] cnt00
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [CW-1:0]       ACC_ONE = CW'(1);
    localparam logic [WIN_LOG2-1:0] SMP_ONE = WIN_LOG2'(1);

    logic                   state_q, state_d;
    logic [WIN_LOG2-1:0]    smp_q, smp_d;
    logic [3:0][CW-1:0]     acc_q, acc_d;
    logic [3:0][CW-1:0]     cnt_q, cnt_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !clear) begin
                    state_d = RUN;
                    smp_d   = '0;
                    acc_d   = '0;
                end
            end
            default: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d[in] = acc_q[in] + ACC_ONE;
                    smp_d     = smp_q + SMP_ONE;
                    // Terminal sample: publish totals including this sample.
                    if (&smp_q) begin
                        cnt_d   = acc_d;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            smp_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign cnt11 = cnt_q[3];
    assign cnt10 = cnt_q[2];
    assign cnt01 = cnt_q[1];
    assign cnt00 = cnt_q[0];

endmodule

// File: tb/tb_stream_pair_monitor.sv
// Bench for stream_pair_monitor (window 16): table vectors, corner sequences and
// random traffic, all checked against a sample-queue reference model.
module tb_stream_pair_monitor;

    localparam int WL  = 4;
    localparam int CW  = WL + 1;
    localparam int WIN = 1 << WL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in = 2'b00;
    logic          busy, done;
    logic [CW-1:0] cnt11, cnt10, cnt01, cnt00;

    int errors = 0;
    int checks = 0;

    // Reference model: collects the window's samples, histograms them when full.
    bit m_busy, m_done;
    int m_cnt[4];
    int samples[$];

    stream_pair_monitor #(.WIN_LOG2(WL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in(in), .busy(busy), .done(done),
        .cnt11(cnt11), .cnt10(cnt10), .cnt01(cnt01), .cnt00(cnt00)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rep;
        bit         st, cl, v;
        logic [1:0] d;
        bit         eb, ed;
        int         c11, c10, c01, c00;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cnt(input int k);
        case (k)
            3: return int'(cnt11);
            2: return int'(cnt10);
            1: return int'(cnt01);
            default: return int'(cnt00);
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_done = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        samples.delete();
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (start && !clear) begin
                m_busy = 1;
                samples.delete();
            end
        end else if (clear) begin
            m_busy = 0;
        end else if (in_valid) begin
            samples.push_back(int'(in));
            if (samples.size() == WIN) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                foreach (samples[i]) m_cnt[samples[i]]++;
                m_done = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic check_model();
        check("model_busy", int'(busy), int'(m_busy));
        check("model_done", int'(done), int'(m_done));
        for (int k = 0; k < 4; k++) check($sformatf("model_cnt%0d", k), dut_cnt(k), m_cnt[k]);
        if (m_done) check("window_sum", int'(cnt11) + int'(cnt10) + int'(cnt01) + int'(cnt00), WIN);
    endtask

    task automatic step(input bit s, input bit c, input bit v, input logic [1:0] d);
        @(negedge clk);
        start = s; clear = c; in_valid = v; in = d;
        @(posedge clk);
        model_edge();
        #1 check_model();
    endtask

    task automatic add(input int rep, input bit st, input bit cl, input bit v, input logic [1:0] d,
                       input bit eb, input bit ed, input int c11, input int c10, input int c01, input int c00);
        vec_t e;
        e.rep = rep; e.st = st; e.cl = cl; e.v = v; e.d = d; e.eb = eb; e.ed = ed;
        e.c11 = c11; e.c10 = c10; e.c01 = c01; e.c00 = c00;
        tbl.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_c11"}, int'(cnt11), 0);
        check({tag, "_c10"}, int'(cnt10), 0);
        check({tag, "_c01"}, int'(cnt01), 0);
        check({tag, "_c00"}, int'(cnt00), 0);
    endtask

    initial begin
        model_reset();
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // start+clear together in IDLE, then clear alone in IDLE
        add(1, 1, 1, 1, 2'b11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        // all-11 window; start-cycle sample ignored
        add(1, 1, 0, 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add(15, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 2'b11, 0, 1, 16, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0, 0, 16, 0, 0, 0);
        // all-00 window, then aborted 01 window, then full 01 window
        add(1, 1, 0, 0, 2'b00, 1, 0, 16, 0, 0, 0);
        add(15, 0, 0, 1, 2'b00, 1, 0, 16, 0, 0, 0);
        add(1, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 16);
        add(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 16);
        add(7, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0, 16);
        add(1, 0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 16);
        add(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 16);
        add(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 16);
        add(15, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0, 16);
        add(1, 0, 0, 1, 2'b01, 0, 1, 0, 0, 16, 0);
        // start during RUN at sample 5 ignored
        add(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 16, 0);
        add(4, 0, 0, 1, 2'b10, 1, 0, 0, 0, 16, 0);
        add(1, 1, 0, 1, 2'b10, 1, 0, 0, 0, 16, 0);
        add(10, 0, 0, 1, 2'b10, 1, 0, 0, 0, 16, 0);
        add(1, 0, 0, 1, 2'b10, 0, 1, 0, 16, 0, 0);
        // start in the done cycle: back-to-back window
        add(1, 1, 0, 1, 2'b11, 1, 0, 0, 16, 0, 0);
        add(15, 0, 0, 1, 2'b00, 1, 0, 0, 16, 0, 0);
        add(1, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 16);
        add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 16);

        foreach (tbl[i]) begin
            repeat (tbl[i].rep) step(tbl[i].st, tbl[i].cl, tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
            check($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].ed));
            check($sformatf("tbl%0d_c11", i), int'(cnt11), tbl[i].c11);
            check($sformatf("tbl%0d_c10", i), int'(cnt10), tbl[i].c10);
            check($sformatf("tbl%0d_c01", i), int'(cnt01), tbl[i].c01);
            check($sformatf("tbl%0d_c00", i), int'(cnt00), tbl[i].c00);
        end

        // in[1]=1, in[0] alternating per valid sample, in_valid toggling
        step(1, 0, 0, 2'b00);
        for (int i = 0; i <= 30; i++)
            step(0, 0, (i % 2) == 0, {1'b1, ((i / 2) % 2) == 0});
        check("alt_done", int'(done), 1);
        check("alt_busy", int'(busy), 0);
        check("alt_c11", int'(cnt11), 8);
        check("alt_c10", int'(cnt10), 8);
        check("alt_c01", int'(cnt01), 0);
        check("alt_c00", int'(cnt00), 0);

        // asynchronous reset mid-window after 10 samples
        step(1, 0, 0, 2'b00);
        repeat (10) step(0, 0, 1, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 2'b00);
        check("post_rst_busy", int'(busy), 1);
        for (int i = 0; i < WIN; i++) step(0, 0, 1, 2'(i % 4));
        check("post_rst_done", int'(done), 1);
        check("post_rst_c11", int'(cnt11), 4);
        check("post_rst_c00", int'(cnt00), 4);

        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
